vec_instr_decode_stage: RTL
===========================

Name: vec_instr_decode_stage

Overview:
- Registered, handshaked decode stage for the vector ASIP front end. Generalised successor of the combinational scalar-op decoder: parametrised instruction, immediate and index widths.
- Owns the scalar loop state: index I, index J and bound N. Updates them on each accepted instruction.
- Emits one registered decode packet per instruction toward the vector execute stage. Detects and flags illegal opcodes.

Parameters:
- INSTR_W, 32, instruction width; opcode is instr[INSTR_W-1 -: 4].
- IMM_W, 24, immediate output width; immediate field is instr[IMM_W-1:0]. Requires IMM_W <= INSTR_W-4.
- IDX_W, 16, width of I, J, N. Requires IDX_W <= IMM_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept an instruction.
- instr  in  INSTR_W  instruction word.
- out_valid  out  1  decode packet valid.
- out_ready  in  1  downstream accepts the packet.
- sca_reg_op  out  2  00 INCRI, 01 INCRJ, 10 SETN, 11 none/vector/illegal.
- vec_op  out  2  00 none, 01 SUMFV, 10 MULFV.
- imm  out  IMM_W  immediate; nonzero only for SETN.
- idx_i  out  IDX_W  I after this instruction.
- idx_j  out  IDX_W  J after this instruction.
- idx_n  out  IDX_W  N after this instruction.
- wrap  out  1  this instruction wrapped I or J to 0.
- illegal  out  1  opcode of this packet is undefined.
- err_sticky  out  1  set on any accepted illegal opcode; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, sca_reg_op=2'b11, vec_op=0, imm=0, idx_i/idx_j/idx_n=0, wrap=0, illegal=0, err_sticky=0. Internal I, J, N = 0.
- in_ready = !out_valid || out_ready (combinational; single-entry pipeline register, no bubble under back-pressure).
- Accept = in_valid && in_ready.
  - On accept, the packet register and I/J/N load at the same edge. Latency: 1 cycle from accept to out_valid=1.
  - No accept and out_ready=1: out_valid clears next cycle.
  - out_valid=1 and out_ready=0: packet and I/J/N hold stable.
- Opcode decode (on accept):
  - 0000 INCRI: I <= (N!=0 && I+1==N) ? 0 : I+1 (mod 2^IDX_W). wrap=1 iff I returned to 0. sca_reg_op=00.
  - 0001 INCRJ: same rule applied to J. sca_reg_op=01.
  - 0010 SETN: N <= instr[IDX_W-1:0]; I, J <= 0. imm = zero-extended instr[IMM_W-1:0]. sca_reg_op=10. wrap=0.
  - 0011 SUMFV: vec_op=01, sca_reg_op=11, state unchanged.
  - 0100 MULFV: vec_op=10, sca_reg_op=11, state unchanged.
  - 0101 NOP: sca_reg_op=11, vec_op=00, state unchanged.
  - 0110-1111: illegal=1, sca_reg_op=11, vec_op=00, imm=0, state unchanged, err_sticky<=1.
  - imm=0 for every opcode except SETN.
- N==0: I and J count freely modulo 2^IDX_W. wrap=1 only on the all-ones→0 rollover.
- A packet's idx_i/idx_j/idx_n reflect state after that instruction. The next instruction sees the updated state (back-to-back INCRI increments twice).
- Reset mid-stream: any pending packet is discarded, state returns to 0, no partial update survives.
- Outputs are driven only from registers; no combinational path from instr to outputs.

Test Plan:
- Reset then SETN with instr[15:0]=3, followed by 4× INCRI, out_ready=1 -> idx_n=3; idx_i sequence 1,2,0,1; wrap=1 only on the third INCRI; every packet appears 1 cycle after its accept.
- SETN 2, then INCRJ ×3 interleaved with SUMFV -> idx_j 1,(1),0,1; SUMFV packet has vec_op=01, sca_reg_op=11, idx_j=1; I stays 0.
- Back-pressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 after the first accept; packet held stable; exactly one state update. Release out_ready -> next instruction accepted the same cycle, no gap.
- Opcode 1010 accepted -> illegal=1, err_sticky=1 and stays 1 through 10 NOPs; I/J/N unchanged.
- N=0 after reset, 2^IDX_W INCRI (IDX_W=4 build) -> idx_i wraps 15→0 with wrap=1 exactly once.
- Assert rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 and all outputs 0/11 immediately, without waiting for a clock edge. The first packet after release shows idx_i=0.

Source files
------------

// File: rtl/vec_instr_decode_stage.sv
// Registered, handshaked decode stage for the vector ASIP front end.
// Owns the scalar loop state (I, J, N) and emits one decode packet per accepted instruction.
module vec_instr_decode_stage #(
   parameter int INSTR_W = 32,
   parameter int IMM_W   = 24,
   parameter int IDX_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         sca_reg_op,
   output logic [1:0]         vec_op,
   output logic [IMM_W-1:0]   imm,
   output logic [IDX_W-1:0]   idx_i,
   output logic [IDX_W-1:0]   idx_j,
   output logic [IDX_W-1:0]   idx_n,
   output logic               wrap,
   output logic               illegal,
   output logic               err_sticky
);

   typedef enum logic [3:0] {
      OP_INCRI = 4'd0,
      OP_INCRJ = 4'd1,
      OP_SETN  = 4'd2,
      OP_SUMFV = 4'd3,
      OP_MULFV = 4'd4,
      OP_NOP   = 4'd5
   } opcode_e;

   localparam logic [1:0] SCA_INCRI = 2'b00;
   localparam logic [1:0] SCA_INCRJ = 2'b01;
   localparam logic [1:0] SCA_SETN  = 2'b10;
   localparam logic [1:0] SCA_NONE  = 2'b11;
   localparam logic [1:0] VEC_NONE  = 2'b00;
   localparam logic [1:0] VEC_SUMFV = 2'b01;
   localparam logic [1:0] VEC_MULFV = 2'b10;

   logic               out_valid_q, out_valid_d;
   logic [1:0]         sca_q, sca_d;
   logic [1:0]         vec_q, vec_d;
   logic [IMM_W-1:0]   imm_q, imm_d;
   logic               wrap_q, wrap_d;
   logic               illegal_q, illegal_d;
   logic               err_q, err_d;
   logic [IDX_W-1:0]   i_q, i_d;
   logic [IDX_W-1:0]   j_q, j_d;
   logic [IDX_W-1:0]   n_q, n_d;

   logic [3:0]         opcode;
   logic               accept;
   logic [IDX_W-1:0]   i_inc, j_inc, i_step, j_step;
   logic               unused_instr;

   assign opcode       = instr[INSTR_W-1 -: 4];
   assign unused_instr = ^instr;
   assign in_ready     = !out_valid_q || out_ready;
   assign accept       = in_valid && in_ready;

   // A bounded counter returns to 0 on reaching N; with N==0 it simply rolls over.
   assign i_inc  = i_q + IDX_W'(1);
   assign j_inc  = j_q + IDX_W'(1);
   assign i_step = (n_q != '0 && i_inc == n_q) ? '0 : i_inc;
   assign j_step = (n_q != '0 && j_inc == n_q) ? '0 : j_inc;

   // NOTE: every _d gets a default (hold) before the case, so no latch can be inferred.
   always_comb begin
      out_valid_d = out_valid_q;
      sca_d       = sca_q;
      vec_d       = vec_q;
      imm_d       = imm_q;
      wrap_d      = wrap_q;
      illegal_d   = illegal_q;
      err_d       = err_q;
      i_d         = i_q;
      j_d         = j_q;
      n_d         = n_q;
      if (accept) begin
         out_valid_d = 1'b1;
         sca_d       = SCA_NONE;
         vec_d       = VEC_NONE;
         imm_d       = '0;
         wrap_d      = 1'b0;
         illegal_d   = 1'b0;
         case (opcode)
            OP_INCRI: begin
               sca_d  = SCA_INCRI;
               i_d    = i_step;
               wrap_d = (i_step == '0);
            end
            OP_INCRJ: begin
               sca_d  = SCA_INCRJ;
               j_d    = j_step;
               wrap_d = (j_step == '0);
            end
            OP_SETN: begin
               sca_d = SCA_SETN;
               imm_d = instr[IMM_W-1:0];
               n_d   = instr[IDX_W-1:0];
               i_d   = '0;
               j_d   = '0;
            end
            OP_SUMFV: vec_d = VEC_SUMFV;
            OP_MULFV: vec_d = VEC_MULFV;
            OP_NOP:   ;
            default: begin
               illegal_d = 1'b1;
               err_d     = 1'b1;
            end
         endcase
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         sca_q       <= SCA_NONE;
         vec_q       <= VEC_NONE;
         imm_q       <= '0;
         wrap_q      <= 1'b0;
         illegal_q   <= 1'b0;
         err_q       <= 1'b0;
         i_q         <= '0;
         j_q         <= '0;
         n_q         <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sca_q       <= sca_d;
         vec_q       <= vec_d;
         imm_q       <= imm_d;
         wrap_q      <= wrap_d;
         illegal_q   <= illegal_d;
         err_q       <= err_d;
         i_q         <= i_d;
         j_q         <= j_d;
         n_q         <= n_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign sca_reg_op = sca_q;
   assign vec_op     = vec_q;
   assign imm        = imm_q;
   assign idx_i      = i_q;
   assign idx_j      = j_q;
   assign idx_n      = n_q;
   assign wrap       = wrap_q;
   assign illegal    = illegal_q;
   assign err_sticky = err_q;

endmodule
